// File: rtl/ifetch_pkg.sv
// Shared types and constants for the Minisys-1A instruction-fetch stage.
// Optional misaligned-target trapping is enabled by defining IFETCH_ALIGN_CHECK_EN.
package ifetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        DROP = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP                = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_F000;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_npc.sv
// Redirect-priority mux: exception > eret > jump > branch; jump/branch need PCWrite.
// Without IFETCH_ALIGN_CHECK_EN the target is forced word-aligned.
module ifetch_npc
    import ifetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        i_pcwrite,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_exc_req,
    input  logic        i_eret,
    input  logic [31:0] i_epc,
    output logic        o_redirect,
    output logic [31:0] o_target
);

    logic [31:0] w_raw_target;

    always_comb begin
        o_redirect   = 1'b1;
        w_raw_target = EXC_VECTOR;
        if (i_exc_req) begin
            w_raw_target = EXC_VECTOR;
        end else if (i_eret) begin
            w_raw_target = i_epc;
        end else if (i_jump && i_pcwrite) begin
            w_raw_target = i_jump_target;
        end else if (i_branch_taken && i_pcwrite) begin
            w_raw_target = i_branch_target;
        end else begin
            o_redirect = 1'b0;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    assign o_target = w_raw_target;
`else
    assign o_target = w_raw_target & 32'hFFFF_FFFC;
`endif

endmodule

// File: rtl/ifetch_unit.sv
// Minisys-1A fetch stage: owns the PC, fetches over a req/ready handshake, buffers one entry.
// Define IFETCH_ALIGN_CHECK_EN to turn misaligned targets into misaligned-fetch markers.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_instruction,
    output logic [31:0] IF_opcplus4,
    output logic [31:0] IF_pc,
    output logic        IF_valid,
    output logic        fetch_stall,
    output logic        fetch_misalign
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_req_addr, w_req_addr_nxt;
    logic [31:0]  r_pending_pc, w_pending_pc_nxt;
    logic [31:0]  r_instr, r_pc, r_opcplus4;
    logic         r_valid, r_misalign;

    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_req_bad, w_seq_bad;
    logic         w_load, w_clear, w_load_mis;
    logic [31:0]  w_load_pc, w_load_data;

    ifetch_npc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_npc (
        .i_pcwrite       (PCWrite),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_exc_req       (exc_req),
        .i_eret          (eret),
        .i_epc           (epc),
        .o_redirect      (w_redirect),
        .o_target        (w_target)
    );

`ifdef IFETCH_ALIGN_CHECK_EN
    assign w_req_bad = is_misaligned(r_req_addr);
    assign w_seq_bad = is_misaligned(r_opcplus4);
`else
    assign w_req_bad = 1'b0;
    assign w_seq_bad = 1'b0;
`endif

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_state <= REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_req_addr_nxt   = r_req_addr;
        w_pending_pc_nxt = r_pending_pc;
        w_load           = 1'b0;
        w_clear          = 1'b0;
        w_load_mis       = 1'b0;
        w_load_pc        = r_req_addr;
        w_load_data      = imem_rdata;
        unique case (r_state)
            REQ: begin
                if (w_redirect) begin
                    // Unanswered request must still complete; its data is dropped later.
                    if (!w_req_bad && !imem_ready) begin
                        w_state_nxt      = DROP;
                        w_pending_pc_nxt = w_target;
                    end else begin
                        w_req_addr_nxt = w_target;
                    end
                end else if (w_req_bad) begin
                    w_load      = 1'b1;
                    w_load_data = NOP;
                    w_load_mis  = 1'b1;
                    w_state_nxt = FULL;
                end else if (imem_ready) begin
                    w_load      = 1'b1;
                    w_state_nxt = FULL;
                end
            end
            DROP: begin
                if (imem_ready) begin
                    w_req_addr_nxt = w_redirect ? w_target : r_pending_pc;
                    w_state_nxt    = REQ;
                end else if (w_redirect) begin
                    w_pending_pc_nxt = w_target;
                end
            end
            FULL: begin
                if (w_redirect) begin
                    w_clear        = 1'b1;
                    w_req_addr_nxt = w_target;
                    w_state_nxt    = REQ;
                end else if (PCWrite) begin
                    if (imem_ready && !w_seq_bad) begin
                        w_load    = 1'b1;
                        w_load_pc = r_opcplus4;
                    end else begin
                        w_clear        = 1'b1;
                        w_req_addr_nxt = r_opcplus4;
                        w_state_nxt    = REQ;
                    end
                end
            end
            default: w_state_nxt = REQ;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_req_addr;
        unique case (r_state)
            REQ:  imem_req = !w_req_bad;
            DROP: imem_req = 1'b1;
            FULL: begin
                imem_addr = r_opcplus4;
                imem_req  = PCWrite && !w_redirect && !w_seq_bad;
            end
            default: imem_req = 1'b0;
        endcase
        if (reset) begin
            imem_req = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_req_addr   <= RESET_PC;
            r_pending_pc <= RESET_PC;
            r_instr      <= NOP;
            r_pc         <= 32'h0;
            r_opcplus4   <= 32'h0;
            r_valid      <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_req_addr   <= w_req_addr_nxt;
            r_pending_pc <= w_pending_pc_nxt;
            if (w_load) begin
                r_instr    <= w_load_data;
                r_pc       <= w_load_pc;
                r_opcplus4 <= w_load_pc + 32'd4;
                r_valid    <= 1'b1;
                r_misalign <= w_load_mis;
            end else if (w_clear) begin
                r_valid    <= 1'b0;
                r_misalign <= 1'b0;
            end
        end
    end

    assign IF_instruction = r_instr;
    assign IF_opcplus4    = r_opcplus4;
    assign IF_pc          = r_pc;
    assign IF_valid       = r_valid;
    assign fetch_stall    = !r_valid;
    assign fetch_misalign = r_misalign;

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage of the Minisys-1A pipeline, directly upstream of the IF/ID pipeline register. Owns the program counter, issues word fetches to instruction memory over a request/ready handshake, and buffers one fetched instruction with its PC+4 for IF/ID to capture. Applies redirects from branch, jump, exception and `eret`, and discards in-flight fetches made stale by a redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded by reset
- EXC_VECTOR, 32'h0000_F000, exception entry address

Ports:
- cpu_clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- PCWrite  in  1  1 = downstream accepts the buffered instruction this cycle; 0 = stall
- branch_taken  in  1  taken branch resolved in ID
- branch_target  in  32  branch destination
- jump  in  1  j/jal/jr resolved in ID
- jump_target  in  32  jump destination
- exc_req  in  1  exception/interrupt entry
- eret  in  1  return from exception
- epc  in  32  return address for eret
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch word address
- imem_rdata  in  32  fetched word, valid when imem_ready=1
- imem_ready  in  1  completes the outstanding request
- IF_instruction  out  32  buffered instruction
- IF_opcplus4  out  32  buffered PC+4
- IF_pc  out  32  buffered PC
- IF_valid  out  1  buffer holds a valid instruction
- fetch_stall  out  1  equals !IF_valid; hazard unit uses it to insert a bubble into IF/ID
- fetch_misalign  out  1  buffered entry is a misaligned-fetch marker (see Configuration)

## Operation
- Redirect priority: exc_req (EXC_VECTOR) > eret (epc) > jump (jump_target) > branch_taken (branch_target).
- exc_req and eret act regardless of PCWrite. jump and branch_taken act only when PCWrite=1.
- States: REQ (request outstanding at req_addr), DROP (outstanding request whose data is discarded), FULL (buffer valid).
- Handshake: once imem_req=1, imem_addr stays stable and imem_req stays high until imem_ready=1. Memory may return ready in the request cycle (zero wait).
- REQ: imem_req=1, imem_addr=req_addr.
  - ready and no redirect: buffer <= {rdata, req_addr, req_addr+4}, go to FULL.
  - redirect and ready: data dropped, req_addr <= target, stay REQ.
  - redirect and no ready: go to DROP, pending_pc <= target.
- DROP: imem_req=1, imem_addr=old req_addr.
  - A further redirect overwrites pending_pc.
  - On ready: data dropped, req_addr <= pending_pc, go to REQ.
- FULL:
  - redirect: buffer invalidated, req_addr <= target, go to REQ. No request this cycle.
  - consume (PCWrite=1, no redirect): imem_req=1, imem_addr=IF_pc+4 in the same cycle. With ready, buffer reloads and state stays FULL. Without ready, go to REQ with req_addr=IF_pc+4.
  - otherwise hold; imem_req=0.
- Address arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Reset values: state REQ, req_addr=RESET_PC, IF_instruction=0, IF_opcplus4=0, IF_pc=0, IF_valid=0, fetch_misalign=0.
- imem_req is forced 0 while reset=1.
- Reset asserted during an outstanding request abandons it. The memory model must tolerate this.

## Timing
- Zero-wait memory: first instruction valid 1 cycle after reset deasserts. Sustained throughput is 1 instruction/cycle while PCWrite=1.
- Redirect to first valid instruction at the target: 2 cycles with zero-wait memory (redirect cycle, then REQ cycle).
- A redirect in the same cycle as imem_ready never loads stale data into the buffer.
- imem_req and imem_addr are combinational from state, PCWrite and the redirect inputs. All other outputs are registered.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined:
  - A target with [1:0]!=0 entering REQ issues no memory request.
  - Next cycle the buffer loads {32'h0, bad_pc, bad_pc+4}, with IF_valid=1 and fetch_misalign=1. ID raises the address exception.
- IFETCH_ALIGN_CHECK_EN undefined: target[1:0] forced to 00; fetch_misalign tied 0.

## Structure
- Package ifetch_pkg holds:
  - the state enum {REQ, DROP, FULL}
  - the NOP constant 32'h0
  - default RESET_PC and EXC_VECTOR constants
- Sub-module ifetch_npc: combinational redirect-priority mux producing {redirect, target}.

## Test plan
- Zero-wait memory, PCWrite=1 throughout after reset → IF_pc sequence 0,4,8,… with one instruction per cycle; IF_opcplus4=IF_pc+4.
- Memory with 3 wait states and a branch_taken to 32'h100 issued in the 2nd wait cycle → old data dropped; next imem_addr=32'h100; IF_valid stays 0 until that fetch returns.
- FULL with PCWrite=0 for 4 cycles, then exc_req → no imem_req during the hold; buffer invalidated; next fetch at 32'h0000_F000.
- exc_req and jump in the same cycle; then eret with epc=32'h0000_0040 → exception wins; after eret, fetch resumes at 32'h40.
- imem_ready in the same cycle as redirect to 32'h200 → stale rdata never appears on IF_instruction; first valid IF_pc=32'h200.
- With IFETCH_ALIGN_CHECK_EN, jump_target=32'h0000_0102 → no imem_req; next cycle IF_valid=1, fetch_misalign=1, IF_pc=32'h102, IF_instruction=0.
